rca_seq_adder: RTL



---
 rtl/rca_seq_adder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rca_seq_adder.sv
// Word-serial wide adder: one N-bit ripple-carry slice is reused over WORDS words, LSW first.
// Define RCA_SEQ_OVF_EN to add the signed-overflow output (ovf).

module rca_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module rca_seq_adder #(
  parameter  int N     = 4,
  parameter  int WORDS = 4,
  localparam int W     = N * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic         ovf
`endif
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic                        carry_q, carry_d;
  logic [WORDS-1:0][N-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [W-1:0]                sum_q, sum_d;
  logic                        cout_q, cout_d;
`ifdef RCA_SEQ_OVF_EN
  logic                        ovf_q, ovf_d;
`endif

  // Slice datapath: c[0] is the stored inter-word carry, c[N] the slice carry-out.
  logic [N:0]   c;
  logic [N-1:0] s;
  assign c[0] = carry_q;

  for (genvar g = 0; g < N; g++) begin : g_fa
    rca_fa u_fa (
      .a_i (a_q[idx_q][g]),
      .b_i (b_q[idx_q][g]),
      .c_i (c[g]),
      .s_o (s[g]),
      .c_o (c[g+1])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef RCA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[idx_q] = s;
        carry_d      = c[N];
        if (idx_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = c[N];
`ifdef RCA_SEQ_OVF_EN
          ovf_d   = c[N] ^ c[N-1];
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef RCA_SEQ_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
